bot_update_hub: RTL

- Parametrised successor to the single-bot update/acknowledge flip-flop in the Nexys4 DDR top level.
- Serves N_BOTS Rojobot channels. For each channel it detects the rising edge of upd_sysregs and snapshots that bot's info word, so the CPU reads a coherent copy.
- Holds a sticky pending flag per channel until the MIPSfpga acknowledges it, counts updates lost to overrun, and presents an aggregate interrupt plus the index of the lowest pending channel.
- Sits between the rojobot instances and the mfp_sys AHB I/O registers, in the clk_50 domain.

---
 rtl/bot_hub_pkg.sv | 20 ++
 rtl/bot_hub_chan.sv | 104 ++++++++++
 rtl/bot_update_hub.sv | 65 ++++++
 3 files changed

// File: rtl/bot_hub_pkg.sv
// rtl/bot_hub_pkg.sv - shared constants and FSM encoding for the bot update hub
package bot_hub_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_PEND = 1'b1;

    // Field offsets inside one bot info word {LocX, LocY, Sensors, BotInfo}
    localparam int LOCX_LSB = 24;
    localparam int LOCY_LSB = 16;
    localparam int SENS_LSB = 8;
    localparam int INFO_LSB = 0;

    localparam int MAX_BOTS = 8;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_PEND = ST_PEND
    } chan_state_e;

endpackage

// File: rtl/bot_hub_chan.sv
// rtl/bot_hub_chan.sv - one bot channel: optional sync (BOT_UPD_SYNC_EN), edge detect, pending FSM, snapshot, overrun counter
module bot_hub_chan #(
    parameter int INFO_W = 32,
    parameter int OVR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_sysregs,
    input  logic [INFO_W-1:0] bot_info,
    input  logic              int_ack,
    input  logic              ovr_clr,
    output logic              pending,
    output logic [INFO_W-1:0] snap_info,
    output logic [OVR_W-1:0]  ovr_count
);
    import bot_hub_pkg::*;

    logic s;
    logic s_d_q, s_d_d;
    logic upd_evt;
    logic ovr_inc;

    chan_state_e       state_q, state_d;
    logic [INFO_W-1:0] snap_q, snap_d;
    logic [OVR_W-1:0]  ovr_q, ovr_d;

`ifdef BOT_UPD_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = upd_sysregs;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s = sync2_q;
`else
    assign s = upd_sysregs;
`endif

    assign upd_evt = s & ~s_d_q;

    always_comb begin
        s_d_d   = s;
        state_d = state_q;
        snap_d  = snap_q;
        ovr_d   = ovr_q;
        ovr_inc = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (upd_evt) begin
                    snap_d  = bot_info;
                    state_d = S_PEND;
                end
            end
            S_PEND: begin
                // An ack in the same cycle consumes the old update, so no overrun
                if (upd_evt) begin
                    snap_d  = bot_info;
                    ovr_inc = ~int_ack;
                end else if (int_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ovr_clr) begin
            ovr_d = ovr_inc ? OVR_W'(1) : '0;
        end else if (ovr_inc && (ovr_q != '1)) begin
            ovr_d = ovr_q + OVR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_d_q   <= 1'b0;
            state_q <= S_IDLE;
            snap_q  <= '0;
            ovr_q   <= '0;
        end else begin
            s_d_q   <= s_d_d;
            state_q <= state_d;
            snap_q  <= snap_d;
            ovr_q   <= ovr_d;
        end
    end

    assign pending   = (state_q == S_PEND);
    assign snap_info = snap_q;
    assign ovr_count = ovr_q;

endmodule

// File: rtl/bot_update_hub.sv
// rtl/bot_update_hub.sv - N-channel rojobot update/ack hub with irq and lowest-pending id (BOT_UPD_SYNC_EN adds input sync)
module bot_update_hub #(
    parameter int N_BOTS = 2,
    parameter int INFO_W = 32,
    parameter int OVR_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_BOTS-1:0]        upd_sysregs,
    input  logic [N_BOTS*INFO_W-1:0] bot_info,
    input  logic [N_BOTS-1:0]        int_ack,
    input  logic [N_BOTS-1:0]        ovr_clr,
    output logic [N_BOTS-1:0]        pending,
    output logic [N_BOTS*INFO_W-1:0] snap_info,
    output logic [N_BOTS*OVR_W-1:0]  ovr_count,
    output logic                     irq,
    output logic [2:0]               pend_id
);
    import bot_hub_pkg::*;

    logic       irq_q, irq_d;
    logic [2:0] pend_id_q, pend_id_d;

    for (genvar g = 0; g < N_BOTS; g++) begin : g_chan
        bot_hub_chan #(
            .INFO_W(INFO_W),
            .OVR_W (OVR_W)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .upd_sysregs(upd_sysregs[g]),
            .bot_info   (bot_info[g*INFO_W +: INFO_W]),
            .int_ack    (int_ack[g]),
            .ovr_clr    (ovr_clr[g]),
            .pending    (pending[g]),
            .snap_info  (snap_info[g*INFO_W +: INFO_W]),
            .ovr_count  (ovr_count[g*OVR_W +: OVR_W])
        );
    end

    // Scan from the top so the lowest pending index is the one left standing
    always_comb begin
        irq_d     = |pending;
        pend_id_d = 3'd0;
        for (int i = N_BOTS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pend_id_d = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q     <= 1'b0;
            pend_id_q <= 3'd0;
        end else begin
            irq_q     <= irq_d;
            pend_id_q <= pend_id_d;
        end
    end

    assign irq     = irq_q;
    assign pend_id = pend_id_q;

endmodule
